// File: rtl/vector_checker_if.sv
// Result handshake between the DUT output port and vector_checker.
// master = result producer (DUT side), slave = checker.
interface vector_checker_if #(
  parameter int DATA_W = 8
);
  logic              dut_valid;
  logic [DATA_W-1:0] dut_data;
  logic              dut_ready;

  modport master (output dut_valid, output dut_data, input dut_ready);
  modport slave  (input dut_valid, input dut_data, output dut_ready);
endinterface

// File: rtl/vector_checker.sv
// vector_checker: holds a table of expected result words, accepts DUT results
// over valid/ready and compares them in order, reporting pass/fail counts and a
// final verdict.
// Optional feature macro: VECTOR_CHECKER_FIRST_FAIL_EN adds first_fail_idx /
// first_fail_data, capturing position and value of the first mismatch in a pass.
module vector_checker #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_wr_en,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic              clr,
  input  logic              start,
  vector_checker_if.slave   dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  nvec,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [CNT_W-1:0]  nvec_q, rd_ptr_q, pass_q, fail_q;
  logic              hs, match, last, full, wr_ok, go;

  // Handshake and table-compare decode; all qualified by registered state.
  assign hs    = (state_q == CHECK) && dut.dut_valid;
  assign match = (dut.dut_data == tbl[rd_ptr_q[AW-1:0]]);
  assign last  = (rd_ptr_q == nvec_q - CNT_W'(1));
  assign full  = (nvec_q == CNT_W'(DEPTH));
  // start beats a same-cycle write; clr beats both.
  assign wr_ok = (state_q == IDLE) && exp_wr_en && !start && !clr && !full;
  // A pass is (re)launched from IDLE or DONE; counts clear on launch.
  assign go    = start && !clr && (state_q != CHECK);

  // Next-state decode; clr overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (nvec_q != '0) ? CHECK : DONE;
      CHECK:   if (hs && last) state_d = DONE;
      DONE:    if (start && nvec_q != '0) state_d = CHECK;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Expected-value table; contents deliberately survive reset and clr since
  // nvec bounds every read.
  always_ff @(posedge clk) begin
    if (wr_ok) tbl[nvec_q[AW-1:0]] <= exp_wr_data;
  end

  // Load count, read pointer and pass/fail counters.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      nvec_q   <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
    end else begin
      if (wr_ok) nvec_q <= nvec_q + CNT_W'(1);
      if (go) begin
        rd_ptr_q <= '0;
        pass_q   <= '0;
        fail_q   <= '0;
      end else if (hs) begin
        rd_ptr_q <= rd_ptr_q + CNT_W'(1);
        if (match) pass_q <= pass_q + CNT_W'(1);
        else       fail_q <= fail_q + CNT_W'(1);
      end
    end
  end

`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
  logic [CNT_W-1:0]  ff_idx_q;
  logic [DATA_W-1:0] ff_data_q;

  // Capture the first mismatch of a pass (fail_q still zero marks "first").
  always_ff @(posedge clk) begin
    if (!rst_n || clr || go) begin
      ff_idx_q  <= '0;
      ff_data_q <= '0;
    end else if (hs && !match && fail_q == '0) begin
      ff_idx_q  <= rd_ptr_q;
      ff_data_q <= dut.dut_data;
    end
  end

  assign first_fail_idx  = ff_idx_q;
  assign first_fail_data = ff_data_q;
`endif

  assign dut.dut_ready = (state_q == CHECK);
  assign busy          = (state_q == CHECK);
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (fail_q == '0) && (nvec_q != '0);
  assign nvec          = nvec_q;
  assign pass_cnt      = pass_q;
  assign fail_cnt      = fail_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed, table-driven bench for vector_checker (DATA_W=8, DEPTH=16, CNT_W=5).
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n, exp_wr_en, clr, start;
  logic [7:0] exp_wr_data;
  logic       busy, done, pass;
  logic [4:0] nvec, pass_cnt, fail_cnt;
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
  logic [4:0] first_fail_idx;
  logic [7:0] first_fail_data;
`endif

  int checks = 0;
  int failures = 0;

  vector_checker_if #(.DATA_W(8)) intf ();

  vector_checker #(.DATA_W(8), .DEPTH(16), .CNT_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .exp_wr_en(exp_wr_en), .exp_wr_data(exp_wr_data),
    .clr(clr), .start(start), .dut(intf.slave),
    .busy(busy), .done(done), .pass(pass),
    .nvec(nvec), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
    , .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, wr; int wd; bit cl, st, vl; int dd;
    bit e_rdy, e_busy, e_done, e_pass; int e_nvec, e_pc, e_fc, e_ffi, e_ffd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(bit rst, bit wr, int wd, bit cl, bit st, bit vl, int dd,
                             bit rdy, bit bsy, bit dn, bit ps, int nv, int pc, int fc,
                             int ffi = 0, int ffd = 0);
    vec_t r;
    r.rst = rst; r.wr = wr; r.wd = wd; r.cl = cl; r.st = st; r.vl = vl; r.dd = dd;
    r.e_rdy = rdy; r.e_busy = bsy; r.e_done = dn; r.e_pass = ps;
    r.e_nvec = nv; r.e_pc = pc; r.e_fc = fc; r.e_ffi = ffi; r.e_ffd = ffd;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit wr, input int wd, input bit cl,
                       input bit st, input bit vl, input int dd);
    rst_n = ~rst; exp_wr_en = wr; exp_wr_data = 8'(wd); clr = cl; start = st;
    intf.dut_valid = vl; intf.dut_data = 8'(dd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; exp_wr_en = 1'b0; exp_wr_data = '0; clr = 1'b0; start = 1'b0;
    intf.dut_valid = 1'b0; intf.dut_data = '0;

    //        rst wr wd    cl st vl dd     rdy bsy dn ps nv pc fc [ffi ffd]
    vq.push_back(v(1, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 'h11, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0));
    vq.push_back(v(0, 1, 'h22, 0, 0, 0, 0,    0, 0, 0, 0, 2, 0, 0));
    vq.push_back(v(0, 1, 'h33, 0, 0, 0, 0,    0, 0, 0, 0, 3, 0, 0));
    vq.push_back(v(0, 1, 'h44, 0, 0, 0, 0,    0, 0, 0, 0, 4, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 1, 0, 0,    1, 1, 0, 0, 4, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h11, 1, 1, 0, 0, 4, 1, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h22, 1, 1, 0, 0, 4, 2, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h33, 1, 1, 0, 0, 4, 3, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h44, 0, 0, 1, 1, 4, 4, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 1, 4, 4, 0));
    // rerun from DONE with mismatches and valid gaps
    vq.push_back(v(0, 0, 0,    0, 1, 0, 0,    1, 1, 0, 0, 4, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h11, 1, 1, 0, 0, 4, 1, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 0, 'h20, 1, 1, 0, 0, 4, 1, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h20, 1, 1, 0, 0, 4, 1, 1, 1, 'h20));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h33, 1, 1, 0, 0, 4, 2, 1, 1, 'h20));
    vq.push_back(v(0, 0, 0,    0, 0, 0, 0,    1, 1, 0, 0, 4, 2, 1, 1, 'h20));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h40, 0, 0, 1, 0, 4, 2, 2, 1, 'h20));
    // restart from DONE, then clr after two handshakes
    vq.push_back(v(0, 0, 0,    0, 1, 0, 0,    1, 1, 0, 0, 4, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h11, 1, 1, 0, 0, 4, 1, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h22, 1, 1, 0, 0, 4, 2, 0));
    vq.push_back(v(0, 0, 0,    1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0));
    // empty table: start+write together -> DONE, write dropped, ready never high
    vq.push_back(v(0, 1, 'h99, 0, 1, 0, 0,    0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h99, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 1, 0, 0,    0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0,    1, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0));
    // single-entry table, start wins over write, then reset mid-CHECK
    vq.push_back(v(0, 1, 'h55, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0));
    vq.push_back(v(0, 1, 'h66, 0, 1, 0, 0,    1, 1, 0, 0, 1, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 1, 'h55, 0, 0, 1, 1, 1, 1, 0));
    vq.push_back(v(0, 0, 0,    0, 1, 0, 0,    1, 1, 0, 0, 1, 0, 0));
    vq.push_back(v(1, 0, 0,    0, 0, 1, 'h55, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].wr, vq[i].wd, vq[i].cl, vq[i].st, vq[i].vl, vq[i].dd);
      chk($sformatf("v%0d.dut_ready", i), int'(intf.dut_ready), int'(vq[i].e_rdy));
      chk($sformatf("v%0d.busy", i),      int'(busy),     int'(vq[i].e_busy));
      chk($sformatf("v%0d.done", i),      int'(done),     int'(vq[i].e_done));
      chk($sformatf("v%0d.pass", i),      int'(pass),     int'(vq[i].e_pass));
      chk($sformatf("v%0d.nvec", i),      int'(nvec),     vq[i].e_nvec);
      chk($sformatf("v%0d.pass_cnt", i),  int'(pass_cnt), vq[i].e_pc);
      chk($sformatf("v%0d.fail_cnt", i),  int'(fail_cnt), vq[i].e_fc);
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
      chk($sformatf("v%0d.first_fail_idx", i),  int'(first_fail_idx),  vq[i].e_ffi);
      chk($sformatf("v%0d.first_fail_data", i), int'(first_fail_data), vq[i].e_ffd);
`endif
    end

    // Overfill: 17 writes into a 16-deep table, then check all 16 back-to-back.
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) drive(0, 1, (i * 7 + 3) & 'hff, 0, 0, 0, 0);
    chk("full.nvec", int'(nvec), 16);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("full.busy", int'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i * 7 + 3) & 'hff);
      if (i == 14) chk("full.not_done_early", int'(done), 0);
    end
    chk("full.done", int'(done), 1);
    chk("full.pass", int'(pass), 1);
    chk("full.pass_cnt", int'(pass_cnt), 16);
    chk("full.fail_cnt", int'(fail_cnt), 0);
    chk("full.ready_low", int'(intf.dut_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
